// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Three requesters write 8-bit data into register A or B through
//            independent round-robin arbiters; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] dst,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [2:0] gnt,
  output logic       load_a,
  output logic       load_b,
  output logic [7:0] wdata_a,
  output logic [7:0] wdata_b
);

  localparam logic [1:0] c_PTR_R0 = 2'd0;
  localparam logic [1:0] c_PTR_R1 = 2'd1;
  localparam logic [1:0] c_PTR_R2 = 2'd2;

  logic [2:0] r_gnt;
  logic       r_load_a;
  logic       r_load_b;
  logic [7:0] r_wdata_a;
  logic [7:0] r_wdata_b;
  logic [1:0] r_ptr_a;
  logic [1:0] r_ptr_b;

  logic [2:0] w_elig_a;
  logic [2:0] w_elig_b;
  logic [2:0] w_win_a;
  logic [2:0] w_win_b;
  logic [1:0] w_ptr_a_nxt;
  logic [1:0] w_ptr_b_nxt;
  logic [7:0] w_data_a;
  logic [7:0] w_data_b;

  // One-hot winner, searching from ptr; an out-of-range pointer acts as 0.
  function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] ptr);
    logic [2:0] win;
    win = 3'b000;
    case (ptr)
      c_PTR_R1: begin
        if      (elig[1]) win = 3'b010;
        else if (elig[2]) win = 3'b100;
        else if (elig[0]) win = 3'b001;
      end
      c_PTR_R2: begin
        if      (elig[2]) win = 3'b100;
        else if (elig[0]) win = 3'b001;
        else if (elig[1]) win = 3'b010;
      end
      default: begin
        if      (elig[0]) win = 3'b001;
        else if (elig[1]) win = 3'b010;
        else if (elig[2]) win = 3'b100;
      end
    endcase
    return win;
  endfunction

  function automatic logic [1:0] ptr_next(input logic [2:0] win, input logic [1:0] ptr);
    logic [1:0] nxt;
    nxt = ptr;
    if      (win[0]) nxt = c_PTR_R1;
    else if (win[1]) nxt = c_PTR_R2;
    else if (win[2]) nxt = c_PTR_R0;
    return nxt;
  endfunction

  function automatic logic [7:0] data_sel(input logic [2:0] win, input logic [7:0] d0,
                                          input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d;
    d = 8'h00;
    if      (win[0]) d = d0;
    else if (win[1]) d = d1;
    else if (win[2]) d = d2;
    return d;
  endfunction

  // A requester granted last cycle sits out this edge so a held req writes once.
  always_comb begin
    w_elig_a    = req & ~dst & ~r_gnt;
    w_elig_b    = req &  dst & ~r_gnt;
    w_win_a     = rr_pick(w_elig_a, r_ptr_a);
    w_win_b     = rr_pick(w_elig_b, r_ptr_b);
    w_ptr_a_nxt = ptr_next(w_win_a, r_ptr_a);
    w_ptr_b_nxt = ptr_next(w_win_b, r_ptr_b);
    w_data_a    = data_sel(w_win_a, data0, data1, data2);
    w_data_b    = data_sel(w_win_b, data0, data1, data2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt     <= 3'b000;
      r_load_a  <= 1'b0;
      r_load_b  <= 1'b0;
      r_wdata_a <= 8'h00;
      r_wdata_b <= 8'h00;
      r_ptr_a   <= c_PTR_R0;
      r_ptr_b   <= c_PTR_R0;
    end else begin
      r_gnt    <= w_win_a | w_win_b;
      r_load_a <= |w_win_a;
      r_load_b <= |w_win_b;
      if (|w_win_a) r_wdata_a <= w_data_a;
      if (|w_win_b) r_wdata_b <= w_data_b;
      r_ptr_a  <= w_ptr_a_nxt;
      r_ptr_b  <= w_ptr_b_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign load_a  = r_load_a;
  assign load_b  = r_load_b;
  assign wdata_a = r_wdata_a;
  assign wdata_b = r_wdata_b;

endmodule
`default_nettype wire
